mips_multicycle_ctrl: RTL

Moore-style main control FSM for the multicycle MIPS core.
- Sequences fetch, decode, execute, memory and write-back over 3–5 cycles per instruction, stalling on a memory-ready handshake.
- Drives every datapath mux and enable, including the immediate extender mode: sign-extend versus zero-extend for ANDI/ORI.
- Sits between the instruction register opcode field and the datapath. ALU function decode stays in the separate ALU control block.

---
 rtl/mips_ctrl_pkg.sv | 61 ++++++
 rtl/mips_ctrl_next_state.sv | 38 +++
 rtl/mips_multicycle_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared opcodes, state encoding and datapath mux-select codes for the multicycle MIPS control FSM.
// The MIPS_CTRL_JAL_EN build option adds the JAL state; the encoding of state 12 is fixed here regardless.
package mips_ctrl_pkg;

    localparam int CTRL_STATE_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    typedef enum logic [CTRL_STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC     = 4'd6,
        S_ALU_WB   = 4'd7,
        S_BRANCH   = 4'd8,
        S_IMM_EXEC = 4'd9,
        S_IMM_WB   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12
    } state_t;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;
    localparam logic [1:0] ALUOP_OPC   = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    localparam logic [1:0] MTR_ALU = 2'd0;
    localparam logic [1:0] MTR_MDR = 2'd1;
    localparam logic [1:0] MTR_PC  = 2'd2;

    // ANDI/ORI take a zero-extended immediate and let ALU control decode the opcode.
    function automatic logic is_logic_imm(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/mips_ctrl_next_state.sv
// Combinational next-state logic for the multicycle MIPS control FSM.
// JAL dispatch from DECODE exists only when MIPS_CTRL_JAL_EN is defined.
module mips_ctrl_next_state
    import mips_ctrl_pkg::*;
(
    input  state_t      state,
    input  logic [5:0]  opcode,
    input  logic        mem_ready,
    output state_t      next_state
);

    always_comb begin
        next_state = S_FETCH;
        case (state)
            S_FETCH:    next_state = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:              next_state = S_MEM_ADDR;
                    OP_RTYPE:                  next_state = S_EXEC;
                    OP_BEQ, OP_BNE:            next_state = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:  next_state = S_IMM_EXEC;
                    OP_J:                      next_state = S_JUMP;
`ifdef MIPS_CTRL_JAL_EN
                    OP_JAL:                    next_state = S_JAL;
`endif
                    default:                   next_state = S_FETCH;
                endcase
            end
            S_MEM_ADDR: next_state = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   next_state = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   next_state = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC:     next_state = S_ALU_WB;
            S_IMM_EXEC: next_state = S_IMM_WB;
            default:    next_state = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Moore-style main control FSM for the multicycle MIPS core: state register plus output decode.
// Define MIPS_CTRL_JAL_EN to add the JAL (state 12) link-and-jump sequence.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               pc_en,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic [1:0]         reg_dst,
    output logic [1:0]         mem_to_reg,
    output logic               reg_write,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic [1:0]         alu_op,
    output logic [1:0]         pc_src,
    output logic               ext_zero,
    output logic [STATE_W-1:0] state_out
);

    state_t state_q, state_d;

    mips_ctrl_next_state u_next_state (
        .state      (state_q),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .next_state (state_d)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    assign state_out = STATE_W'(state_q);

    // Reset forces every output low even before the first edge lands the state in FETCH.
    always_comb begin
        pc_en      = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = REGDST_RT;
        mem_to_reg = MTR_ALU;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_op     = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        ext_zero   = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_en     = mem_ready;
                end
                S_DECODE:   alu_src_b = SRCB_IMM_SH;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = MTR_MDR;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                S_ALU_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = REGDST_RD;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_SUB;
                    pc_src    = PCSRC_ALUOUT;
                    pc_en     = (opcode == OP_BNE) ? !zero : zero;
                end
                S_IMM_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = is_logic_imm(opcode) ? ALUOP_OPC : ALUOP_ADD;
                    ext_zero  = is_logic_imm(opcode);
                end
                S_IMM_WB: begin
                    reg_write = 1'b1;
                    ext_zero  = is_logic_imm(opcode);
                end
                S_JUMP: begin
                    pc_en  = 1'b1;
                    pc_src = PCSRC_JUMP;
                end
`ifdef MIPS_CTRL_JAL_EN
                S_JAL: begin
                    pc_en      = 1'b1;
                    pc_src     = PCSRC_JUMP;
                    reg_write  = 1'b1;
                    reg_dst    = REGDST_RA;
                    mem_to_reg = MTR_PC;
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
